// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of mem_access_unit, bundled as one port.
interface mem_access_unit_if;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_wr;
  logic [63:0] mem_rdata;
  logic [63:0] load_data;
  logic        busy;
  logic        done;
  logic        misalign;

  // Handshake: start is a one-cycle strobe taken only while busy is low (a start
  // coinciding with done is dropped); done pulses once per accepted request.
  modport slave (
    input  start, is_store, funct3, addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, load_data, busy, done, misalign
  );

  modport master (
    output start, is_store, funct3, addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, load_data, busy, done, misalign
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer between a core and a doubleword data memory:
// sub-dword loads are extracted and extended, partial stores use read-modify-write.
module mem_access_unit #(
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RDWAIT = 3'd2,
    WR     = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] mem_wdata_q;
  logic [63:0] load_data_q;
  logic        misalign_q;

  logic        accept;
  logic [1:0]  req_size;
  logic [2:0]  req_off;
  logic        req_mis;
  logic        read_exit;

  logic [1:0]  size;
  logic [5:0]  shamt;
  logic        sgn;
  logic [63:0] lane_mask;
  logic [63:0] field;
  logic [63:0] ext;
  logic [63:0] merged;

  assign accept   = (state_q == IDLE) && bus.start;
  assign req_size = bus.funct3[1:0];
  assign req_off  = bus.addr[2:0];

  // Misalignment is decided on the live request so it can steer the accepting edge.
  always_comb begin
    req_mis = 1'b0;
    case (req_size)
      2'd0:    req_mis = 1'b0;
      2'd1:    req_mis = req_off[0];
      2'd2:    req_mis = |req_off[1:0];
      default: req_mis = |req_off;
    endcase
  end

  assign size  = funct3_q[1:0];
  assign shamt = {addr_q[2:0], 3'b000};
  assign sgn   = ~funct3_q[2];
  assign field = bus.mem_rdata >> shamt;

  always_comb begin
    lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    ext       = field;
    case (size)
      2'd0: begin
        lane_mask = 64'h0000_0000_0000_00FF;
        ext       = {{56{sgn & field[7]}}, field[7:0]};
      end
      2'd1: begin
        lane_mask = 64'h0000_0000_0000_FFFF;
        ext       = {{48{sgn & field[15]}}, field[15:0]};
      end
      2'd2: begin
        lane_mask = 64'h0000_0000_FFFF_FFFF;
        ext       = {{32{sgn & field[31]}}, field[31:0]};
      end
      default: begin
        lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        ext       = field;
      end
    endcase
  end

  assign merged = (bus.mem_rdata & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    read_exit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (req_mis)                                state_d = DONE;
          else if (bus.is_store && req_size == 2'd3)  state_d = WR;
          else                                        state_d = RD;
        end
      end
      RD: begin
        if (RD_LAT == 1) begin
          read_exit = 1'b1;
          state_d   = is_store_q ? WR : DONE;
        end else begin
          state_d = RDWAIT;
          cnt_d   = 2'd0;
        end
      end
      RDWAIT: begin
        if (cnt_q == WAIT_LAST) begin
          read_exit = 1'b1;
          state_d   = is_store_q ? WR : DONE;
          cnt_d     = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      mem_wdata_q <= 64'd0;
      load_data_q <= 64'd0;
      misalign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        is_store_q <= bus.is_store;
        funct3_q   <= bus.funct3;
        addr_q     <= bus.addr;
        wdata_q    <= bus.wdata;
        misalign_q <= req_mis;
        if (bus.is_store && req_size == 2'd3 && !req_mis) mem_wdata_q <= bus.wdata;
      end
      // The read phase ends on the edge where mem_rdata is valid for the driven address.
      if (read_exit) begin
        if (is_store_q) mem_wdata_q <= merged;
        else            load_data_q <= ext;
      end
    end
  end

  assign bus.mem_addr  = {addr_q[63:3], 3'b000};
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr    = (state_q == WR);
  assign bus.load_data = load_data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.misalign  = misalign_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: RD_LAT=1 and RD_LAT=3 instances share one stimulus,
// each with its own doubleword memory model.
module tb_mem_access_unit;

  localparam int          LAT_A   = 1;
  localparam int          LAT_B   = 3;
  localparam logic [63:0] INIT_10 = 64'h8877_6655_4433_2211;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if if_a ();
  mem_access_unit_if if_b ();
  logic [2:0] dbg_a, dbg_b;

  mem_access_unit #(.RD_LAT(LAT_A)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a), .dbg_state_o(dbg_a));
  mem_access_unit #(.RD_LAT(LAT_B)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b), .dbg_state_o(dbg_b));

  assign if_b.start    = if_a.start;
  assign if_b.is_store = if_a.is_store;
  assign if_b.funct3   = if_a.funct3;
  assign if_b.addr     = if_a.addr;
  assign if_b.wdata    = if_a.wdata;

  // Memories: reloaded while reset is low; B returns data through two extra register stages.
  logic [63:0] mem_a [16];
  logic [63:0] mem_b [16];
  logic [63:0] rd_b1, rd_b2;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] <= (i == 2) ? INIT_10 : 64'd0;
        mem_b[i] <= (i == 2) ? INIT_10 : 64'd0;
      end
    end else begin
      if (if_a.mem_wr) mem_a[if_a.mem_addr[6:3]] <= if_a.mem_wdata;
      if (if_b.mem_wr) mem_b[if_b.mem_addr[6:3]] <= if_b.mem_wdata;
    end
    rd_b1 <= mem_b[if_b.mem_addr[6:3]];
    rd_b2 <= rd_b1;
  end

  assign if_a.mem_rdata = mem_a[if_a.mem_addr[6:3]];
  assign if_b.mem_rdata = rd_b2;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-level memory image plus architectural load/misalign state.
  logic [63:0] m_mem [16];
  logic [63:0] m_load;
  logic        m_mis;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = (i == 2) ? INIT_10 : 64'd0;
    m_load = 64'd0;
    m_mis  = 1'b0;
  endtask

  task automatic model_op(input logic st, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, output int lat_a, output int lat_b, output int nwr);
    int nb, off, idx;
    logic [63:0] v;
    bit sx;
    nb  = 1 << f3[1:0];
    off = int'(a[2:0]);
    idx = int'(a[6:3]);
    m_mis = ((off % nb) != 0);
    nwr = 0;
    if (m_mis) begin
      lat_a = 1;
      lat_b = 1;
    end else if (st) begin
      for (int i = 0; i < nb; i++) m_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
      nwr   = 1;
      lat_a = (nb == 8) ? 2 : 2 + LAT_A;
      lat_b = (nb == 8) ? 2 : 2 + LAT_B;
    end else begin
      v = 64'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = m_mem[idx][8*(off+i) +: 8];
      sx = !f3[2] && (nb < 8);
      if (sx && v[8*nb-1]) for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
      m_load = v;
      lat_a  = 1 + LAT_A;
      lat_b  = 1 + LAT_B;
    end
  endtask

  typedef struct {
    logic [63:0] load_a, load_b;
    logic        mis_a, mis_b;
    int          lat_a, lat_b, wr_a, wr_b;
    bit          ok_a, ok_b;
  } obs_t;

  // Issues one request; rep = cycle index at which start is pulsed again (0 = never).
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input int rep, input bit rel_rst, output obs_t o);
    o.lat_a = 0; o.lat_b = 0; o.wr_a = 0; o.wr_b = 0; o.ok_a = 1'b1; o.ok_b = 1'b1;
    @(negedge clk);
    if (rel_rst) rst = 1'b1;
    if_a.start    = 1'b1;
    if_a.is_store = st;
    if_a.funct3   = f3;
    if_a.addr     = a;
    if_a.wdata    = wd;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if_a.start = (k == rep);
      if (k == 1) begin
        if_a.is_store = 1'($urandom);
        if_a.funct3   = 3'($urandom);
        if_a.addr     = {$urandom, $urandom};
        if_a.wdata    = {$urandom, $urandom};
      end
      if (if_a.mem_wr) o.wr_a++;
      if (if_b.mem_wr) o.wr_b++;
      if (o.lat_a == 0) begin
        if (!if_a.busy) o.ok_a = 1'b0;
        if (if_a.done) o.lat_a = k;
      end else if (if_a.busy || if_a.done) o.ok_a = 1'b0;
      if (o.lat_b == 0) begin
        if (!if_b.busy) o.ok_b = 1'b0;
        if (if_b.done) o.lat_b = k;
      end else if (if_b.busy || if_b.done) o.ok_b = 1'b0;
      if (o.lat_a != 0 && o.lat_b != 0 && k >= ((o.lat_a > o.lat_b) ? o.lat_a : o.lat_b) + 2) break;
    end
    if_a.start = 1'b0;
    o.load_a = if_a.load_data;
    o.load_b = if_b.load_data;
    o.mis_a  = if_a.misalign;
    o.mis_b  = if_b.misalign;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [63:0] a, wd, exp_load;
    logic        exp_mis;
    int          lat_a, lat_b, nwr;
    logic [63:0] exp_mem;
    int          rep;
  } vec_t;

  vec_t vt[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int la, lb, nw, done_seen;
    logic [63:0] e;
    logic [63:0] ra;
    logic        rs;
    logic [2:0]  rf;

    rst = 1'b0;
    if_a.start = 1'b0; if_a.is_store = 1'b0; if_a.funct3 = 3'd0;
    if_a.addr = 64'd0; if_a.wdata = 64'd0;
    model_reset();

    vt[0]  = '{1'b0, 3'b000, 64'h17, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 2, 4, 0, INIT_10, 0};
    vt[1]  = '{1'b0, 3'b101, 64'h16, 64'h0, 64'h0000_0000_0000_8877, 1'b0, 2, 4, 0, INIT_10, 0};
    vt[2]  = '{1'b0, 3'b010, 64'h14, 64'h0, 64'hFFFF_FFFF_8877_6655, 1'b0, 2, 4, 0, INIT_10, 0};
    vt[3]  = '{1'b1, 3'b001, 64'h12, 64'hABCD, 64'hFFFF_FFFF_8877_6655, 1'b0, 3, 5, 1,
               64'h8877_6655_ABCD_2211, 0};
    vt[4]  = '{1'b0, 3'b011, 64'h0C, 64'h0, 64'hFFFF_FFFF_8877_6655, 1'b1, 1, 1, 0, 64'h0, 1};
    vt[5]  = '{1'b0, 3'b011, 64'h10, 64'h0, 64'h8877_6655_ABCD_2211, 1'b0, 2, 4, 0,
               64'h8877_6655_ABCD_2211, 0};
    vt[6]  = '{1'b0, 3'b111, 64'h10, 64'h0, 64'h8877_6655_ABCD_2211, 1'b0, 2, 4, 0,
               64'h8877_6655_ABCD_2211, 0};
    vt[7]  = '{1'b1, 3'b011, 64'h18, 64'h0123_4567_89AB_CDEF, 64'h8877_6655_ABCD_2211, 1'b0, 2, 2, 1,
               64'h0123_4567_89AB_CDEF, 0};
    vt[8]  = '{1'b1, 3'b010, 64'h1A, 64'hDEAD_BEEF, 64'h8877_6655_ABCD_2211, 1'b1, 1, 1, 0,
               64'h0123_4567_89AB_CDEF, 0};
    vt[9]  = '{1'b0, 3'b100, 64'h1F, 64'h0, 64'h0000_0000_0000_0001, 1'b0, 2, 4, 0,
               64'h0123_4567_89AB_CDEF, 0};
    vt[10] = '{1'b0, 3'b001, 64'h18, 64'h0, 64'hFFFF_FFFF_FFFF_CDEF, 1'b0, 2, 4, 0,
               64'h0123_4567_89AB_CDEF, 0};
    vt[11] = '{1'b1, 3'b000, 64'h21, 64'h5A, 64'hFFFF_FFFF_FFFF_CDEF, 1'b0, 3, 5, 1, 64'h5A00, 2};

    repeat (3) @(negedge clk);
    check("rst mem_addr_a", if_a.mem_addr, 64'd0);
    check("rst mem_addr_b", if_b.mem_addr, 64'd0);
    check("rst mem_wdata_a", if_a.mem_wdata, 64'd0);
    check("rst mem_wdata_b", if_b.mem_wdata, 64'd0);
    check("rst mem_wr_a", 64'(if_a.mem_wr), 64'd0);
    check("rst mem_wr_b", 64'(if_b.mem_wr), 64'd0);
    check("rst load_a", if_a.load_data, 64'd0);
    check("rst load_b", if_b.load_data, 64'd0);
    check("rst busy_a", 64'(if_a.busy), 64'd0);
    check("rst busy_b", 64'(if_b.busy), 64'd0);
    check("rst done_a", 64'(if_a.done), 64'd0);
    check("rst done_b", 64'(if_b.done), 64'd0);
    check("rst mis_a", 64'(if_a.misalign), 64'd0);
    check("rst mis_b", 64'(if_b.misalign), 64'd0);

    for (int i = 0; i < 12; i++) begin
      model_op(vt[i].st, vt[i].f3, vt[i].a, vt[i].wd, la, lb, nw);
      do_op(vt[i].st, vt[i].f3, vt[i].a, vt[i].wd, vt[i].rep, (i == 0), o);
      check($sformatf("v%0d load_a", i), o.load_a, vt[i].exp_load);
      check($sformatf("v%0d load_b", i), o.load_b, vt[i].exp_load);
      check($sformatf("v%0d mis_a", i), 64'(o.mis_a), 64'(vt[i].exp_mis));
      check($sformatf("v%0d mis_b", i), 64'(o.mis_b), 64'(vt[i].exp_mis));
      check($sformatf("v%0d lat_a", i), 64'(o.lat_a), 64'(vt[i].lat_a));
      check($sformatf("v%0d lat_b", i), 64'(o.lat_b), 64'(vt[i].lat_b));
      check($sformatf("v%0d writes_a", i), 64'(o.wr_a), 64'(vt[i].nwr));
      check($sformatf("v%0d writes_b", i), 64'(o.wr_b), 64'(vt[i].nwr));
      check($sformatf("v%0d mem_a", i), mem_a[vt[i].a[6:3]], vt[i].exp_mem);
      check($sformatf("v%0d mem_b", i), mem_b[vt[i].a[6:3]], vt[i].exp_mem);
      check($sformatf("v%0d busy_a", i), 64'(o.ok_a), 64'd1);
      check($sformatf("v%0d busy_b", i), 64'(o.ok_b), 64'd1);
    end

    // Reset while the RD_LAT=1 instance is in WR of a partial store.
    @(negedge clk);
    if_a.start = 1'b1; if_a.is_store = 1'b1; if_a.funct3 = 3'b000;
    if_a.addr = 64'h41; if_a.wdata = 64'h77;
    @(negedge clk);
    if_a.start = 1'b0;
    @(negedge clk);
    check("midwr mem_wr before", 64'(if_a.mem_wr), 64'd1);
    rst = 1'b0;
    #1;
    check("midwr mem_wr after", 64'(if_a.mem_wr), 64'd0);
    check("midwr busy_a", 64'(if_a.busy), 64'd0);
    check("midwr busy_b", 64'(if_b.busy), 64'd0);
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (if_a.done || if_b.done || if_a.mem_wr || if_b.mem_wr) done_seen++;
    end
    check("midwr no done", 64'(done_seen), 64'd0);
    model_reset();
    check("midwr load_a", if_a.load_data, m_load);
    check("midwr load_b", if_b.load_data, m_load);

    model_op(1'b1, 3'b001, 64'h42, 64'h1234, la, lb, nw);
    do_op(1'b1, 3'b001, 64'h42, 64'h1234, 0, 1'b1, o);
    check("post rst lat_a", 64'(o.lat_a), 64'(la));
    check("post rst lat_b", 64'(o.lat_b), 64'(lb));
    check("post rst mem_a", mem_a[8], m_mem[8]);
    check("post rst mem_b", mem_b[8], m_mem[8]);

    for (int n = 0; n < 80; n++) begin
      rs = 1'($urandom);
      rf = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) ra[2:0] = 3'd0;
      e  = {$urandom, $urandom};
      model_op(rs, rf, ra, e, la, lb, nw);
      exp_q.push_back(m_load);
      do_op(rs, rf, ra, e, 0, 1'b0, o);
      e = exp_q.pop_front();
      check($sformatf("r%0d load_a", n), o.load_a, e);
      check($sformatf("r%0d load_b", n), o.load_b, e);
      check($sformatf("r%0d mis_a", n), 64'(o.mis_a), 64'(m_mis));
      check($sformatf("r%0d mis_b", n), 64'(o.mis_b), 64'(m_mis));
      check($sformatf("r%0d lat_a", n), 64'(o.lat_a), 64'(la));
      check($sformatf("r%0d lat_b", n), 64'(o.lat_b), 64'(lb));
      check($sformatf("r%0d writes_a", n), 64'(o.wr_a), 64'(nw));
      check($sformatf("r%0d writes_b", n), 64'(o.wr_b), 64'(nw));
      check($sformatf("r%0d mem_a", n), mem_a[ra[6:3]], m_mem[ra[6:3]]);
      check($sformatf("r%0d mem_b", n), mem_b[ra[6:3]], m_mem[ra[6:3]]);
      check($sformatf("r%0d busy_a", n), 64'(o.ok_a), 64'd1);
      check($sformatf("r%0d busy_b", n), 64'(o.ok_b), 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
